// File: rtl/edge_event_gen.sv
// Command-driven edge/event generator: a small FIFO of timed commands feeds a
// controller that produces guaranteed sig1 rising edges, sig2 falling edges and ev pulses.
module edge_event_gen #(
  parameter int DEPTH = 4,
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DLY_W-1:0] cmd_dly,
  input  logic             abort,
  output logic             sig1,
  output logic             sig2,
  output logic             ev,
  output logic             busy,
  output logic [15:0]      issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    OP_EV_PULSE  = 2'b00,
    OP_SIG1_RISE = 2'b01,
    OP_SIG2_FALL = 2'b10,
    OP_SIG1_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {IDLE, WAIT, PREP, FIRE} state_e;

  typedef struct packed {
    op_e              op;
    logic [DLY_W-1:0] dly;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             cmd_ready_q;
  logic             push, pop;
  cmd_t             head;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             sig1_q, sig1_d, sig2_q, sig2_d, ev_q, ev_d;
  logic [15:0]      issued_q, issued_d;
  logic             do_effect;

  assign push = cmd_valid & cmd_ready_q & ~abort;
  assign head = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; validity is tracked by count_q, so the array
  // can map onto plain flops or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: op_e'(cmd_op), dly: cmd_dly};
  end

  assign count_d = abort ? '0 : count_q + CW'(push) - CW'(pop);

  // A level that already sits at the effect level needs one cycle at the opposite level first.
  function automatic logic need_prep(op_e op, logic s1, logic s2);
    return (op == OP_SIG1_RISE && s1) || (op == OP_SIG2_FALL && !s2);
  endfunction

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    sig1_d    = sig1_q;
    sig2_d    = sig2_q;
    ev_d      = 1'b0;
    issued_d  = issued_q;
    pop       = 1'b0;
    do_effect = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (count_q != '0) begin
          pop     = 1'b1;
          op_d    = head.op;
          cnt_d   = head.dly;
          state_d = (head.dly != '0) ? WAIT : FIRE;
        end
        WAIT: begin
          cnt_d = cnt_q - DLY_W'(1);
          if (cnt_q == DLY_W'(1)) state_d = FIRE;
        end
        FIRE: if (need_prep(op_q, sig1_q, sig2_q)) begin
          if (op_q == OP_SIG1_RISE) sig1_d = 1'b0;
          else                      sig2_d = 1'b1;
          state_d = PREP;
        end else begin
          do_effect = 1'b1;
        end
        PREP:    do_effect = 1'b1;
        default: state_d = IDLE;
      endcase
    end
    if (do_effect) begin
      state_d = IDLE;
      case (op_q)
        OP_EV_PULSE:  ev_d   = 1'b1;
        OP_SIG1_RISE: sig1_d = 1'b1;
        OP_SIG2_FALL: sig2_d = 1'b0;
        OP_SIG1_CLR:  sig1_d = 1'b0;
        default:      ev_d   = 1'b0;
      endcase
      if (issued_q != 16'hFFFF) issued_d = issued_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      state_q     <= IDLE;
      op_q        <= OP_EV_PULSE;
      cnt_q       <= '0;
      sig1_q      <= 1'b0;
      sig2_q      <= 1'b1;
      ev_q        <= 1'b0;
      issued_q    <= '0;
    end else begin
      if (abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q     <= count_d;
      cmd_ready_q <= (count_d != CW'(DEPTH));
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      sig1_q      <= sig1_d;
      sig2_q      <= sig2_d;
      ev_q        <= ev_d;
      issued_q    <= issued_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign sig1       = sig1_q;
  assign sig2       = sig2_q;
  assign ev         = ev_q;
  assign issued_cnt = issued_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_edge_event_gen.sv
// Table-driven bench for edge_event_gen: each row drives one or more cycles and
// queues the expected outputs, which are compared at the following negedge.
module tb_edge_event_gen;

  localparam logic [1:0] OP_EV = 2'b00, OP_R = 2'b01, OP_F = 2'b10, OP_C = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_dly = 8'd0;
  logic        abort = 1'b0;
  logic        sig1, sig2, ev, busy;
  logic [15:0] issued_cnt;

  edge_event_gen #(.DEPTH(4), .DLY_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dly(cmd_dly), .abort(abort), .sig1(sig1), .sig2(sig2),
    .ev(ev), .busy(busy), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [7:0]  dly;
    logic        abrt;
    int          reps;
    logic [20:0] exp;   // {sig1, sig2, ev, busy, cmd_ready, issued_cnt}
  } vec_t;

  vec_t        tbl[$];
  logic [20:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  int          sig1_rises = 0;
  int          sig2_falls = 0;

  always @(posedge sig1) sig1_rises++;
  always @(negedge sig2) sig2_falls++;

  function automatic vec_t mk(logic v, logic [1:0] op, logic [7:0] dly, logic ab, int reps,
                              logic s1, logic s2, logic e, logic b, logic r, logic [15:0] iss);
    vec_t t;
    t.valid = v; t.op = op; t.dly = dly; t.abrt = ab; t.reps = reps;
    t.exp = {s1, s2, e, b, r, iss};
    return t;
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got s1s2/ev/busy/rdy=%b iss=%0d, expected %b iss=%0d",
               name, act[20:16], act[15:0], exp[20:16], exp[15:0]);
    end
  endtask

  function automatic logic [20:0] outs();
    return {sig1, sig2, ev, busy, cmd_ready, issued_cnt};
  endfunction

  // Asynchronous reset applied away from the clock edge; outputs must clear at once.
  task automatic do_reset(input string name);
    cmd_valid = 1'b0; abort = 1'b0;
    rst_n = 1'b0;
    #1;
    check({name, " reset"}, outs(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string name);
    logic [20:0] e;
    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        cmd_valid = tbl[i].valid;
        cmd_op    = tbl[i].op;
        cmd_dly   = tbl[i].dly;
        abort     = tbl[i].abrt;
        sb.push_back(tbl[i].exp);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check($sformatf("%s row%0d rep%0d", name, i, r), outs(), e);
      end
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    tbl.delete();
  endtask

  initial begin
    int snap;
    @(negedge clk);
    do_reset("init");

    // EV_PULSE dly=2 pushed at edge 1: pop at 2, ev high only after edge 5.
    tbl.push_back(mk(1, OP_EV, 2, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, OP_EV, 0, 0, 3, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, OP_EV, 0, 0, 1, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, OP_EV, 0, 0, 2, 0, 1, 0, 0, 1, 1));
    run_table("ev_pulse");

    // Two SIG1_RISE dly=0: second one dips sig1 for one cycle.
    do_reset("rise2");
    snap = sig1_rises;
    tbl.push_back(mk(1, OP_R, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, OP_R, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, OP_R, 0, 0, 1, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_R, 0, 0, 1, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_R, 0, 0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_R, 0, 0, 1, 1, 1, 0, 0, 1, 2));
    run_table("rise2");
    check("rise2 edge count", 21'(sig1_rises - snap), 21'd2);

    // Fill the FIFO behind a long WAIT; the held offer is taken right after a pop.
    do_reset("fill");
    tbl.push_back(mk(1, OP_EV, 10, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, OP_EV, 10, 0, 3, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, OP_EV, 10, 0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, OP_EV, 10, 0, 7, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, OP_EV, 10, 0, 1, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, OP_EV, 10, 0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(1, OP_EV, 10, 0, 1, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, OP_EV, 0, 1, 1, 0, 1, 0, 0, 1, 1));
    run_table("fill");

    // SIG2_FALL dly=1 then dly=0: second goes through PREP, exactly two negedges.
    do_reset("fall2");
    snap = sig2_falls;
    tbl.push_back(mk(1, OP_F, 1, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, OP_F, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, OP_F, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, OP_F, 0, 0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_F, 0, 0, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_F, 0, 0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_F, 0, 0, 2, 0, 0, 0, 0, 1, 2));
    run_table("fall2");
    check("fall2 edge count", 21'(sig2_falls - snap), 21'd2);

    // Abort while the first of three queued commands waits.
    do_reset("abort_wait");
    tbl.push_back(mk(1, OP_R, 3, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, OP_EV, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, OP_F, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, OP_EV, 0, 1, 1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, OP_EV, 0, 0, 5, 0, 1, 0, 0, 1, 0));
    run_table("abort_wait");

    // Abort during PREP leaves sig1 at the opposite (low) level.
    do_reset("abort_prep");
    tbl.push_back(mk(1, OP_R, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, OP_R, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, OP_R, 0, 0, 2, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_R, 0, 0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_R, 0, 1, 1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, OP_R, 0, 0, 2, 0, 1, 0, 0, 1, 1));
    run_table("abort_prep");

    // SIG1_CLR clears without any edge guarantee.
    do_reset("clr");
    tbl.push_back(mk(1, OP_R, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, OP_C, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, OP_C, 0, 0, 1, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_C, 0, 0, 1, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_C, 0, 0, 1, 0, 1, 0, 1, 1, 2));
    tbl.push_back(mk(0, OP_C, 0, 0, 1, 0, 1, 0, 1, 1, 2));
    tbl.push_back(mk(0, OP_C, 0, 0, 1, 0, 1, 0, 0, 1, 3));
    run_table("clr");

    // Reset while in PREP with sig1 low: nothing fires after release.
    do_reset("rst_prep");
    tbl.push_back(mk(1, OP_R, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, OP_R, 0, 0, 1, 0, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, OP_R, 0, 0, 2, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, OP_R, 0, 0, 1, 0, 1, 0, 1, 1, 1));
    run_table("rst_prep");
    do_reset("rst_prep mid");
    snap = sig1_rises;
    tbl.push_back(mk(0, OP_R, 0, 0, 5, 0, 1, 0, 0, 1, 0));
    run_table("rst_prep after");
    check("rst_prep no edge", 21'(sig1_rises - snap), 21'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
